fetch_stage: RTL and testbench

//  Instruction fetch stage plus IF/ID pipeline register; feeds decode_stage (o_instr -> i_instr,
//  o_interrupt -> i_interrupt). Owns the PC: boots from a reset vector, steps sequentially,

---
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_stage.sv | 166 ++++++++++++++++
 tb/tb_fetch_stage.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: control inputs from decode/execute, the async
// instruction memory port, and the IF/ID register outputs.
interface fetch_stage_if;
    logic        i_stall;
    logic        i_redirect;
    logic [15:0] i_redirect_pc;
    logic        i_interrupt;
    logic [15:0] i_imem_data;
    logic [15:0] o_imem_addr;
    logic [15:0] o_instr;
    logic [15:0] o_pc_plus1;
    logic        o_valid;
    logic        o_interrupt;

    // Side that drives the fetch stage (pipeline control, memory, test bench)
    modport master (
        output i_stall, i_redirect, i_redirect_pc, i_interrupt, i_imem_data,
        input  o_imem_addr, o_instr, o_pc_plus1, o_valid, o_interrupt
    );

    // The fetch stage itself
    modport slave (
        input  i_stall, i_redirect, i_redirect_pc, i_interrupt, i_imem_data,
        output o_imem_addr, o_instr, o_pc_plus1, o_valid, o_interrupt
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Owns the PC: boots from the reset vector word, steps sequentially, takes
// redirects and stalls, and turns an interrupt edge into a one-cycle marker
// in IF/ID followed by a load of the PC from the interrupt vector word.
module fetch_stage #(
    parameter logic [15:0] RESET_VEC_ADDR = 16'h0000,
    parameter logic [15:0] INT_VEC_ADDR   = 16'h0001,
    parameter logic [15:0] NOP_INSTR      = 16'h0000
) (
    input logic          i_clk,
    input logic          i_reset,
    fetch_stage_if.slave bus
);

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_INT_VEC = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // PC of the word currently being fetched
    logic [15:0] pc_p0;
    logic [15:0] pc_nxt;

    // Interrupt edge detection and the latched request
    logic        int_q;
    logic        int_edge;
    logic        pending;
    logic        pending_nxt;

    // IF/ID register
    logic [15:0] instr_p1;
    logic [15:0] pc_plus1_p1;
    logic        vld_p1;
    logic        int_p1;
    logic [15:0] instr_nxt;
    logic [15:0] pc_plus1_nxt;
    logic        vld_nxt;
    logic        int_nxt;

    // 16-bit modulo increment; FFFF wraps to 0000 silently
    function automatic logic [15:0] pc_inc(input logic [15:0] pc);
        return pc + 16'd1;
    endfunction

    assign int_edge = bus.i_interrupt & ~int_q;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, PC, pending-interrupt and IF/ID selection
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc_p0;
        pending_nxt  = pending | int_edge;
        instr_nxt    = instr_p1;
        pc_plus1_nxt = pc_plus1_p1;
        vld_nxt      = vld_p1;
        int_nxt      = int_p1;

        case (state)
            ST_BOOT: begin
                // Stall and redirect have no meaning before the first fetch
                pc_nxt    = bus.i_imem_data;
                state_nxt = ST_RUN;
            end

            ST_RUN: begin
                if (bus.i_redirect) begin
                    pc_nxt    = bus.i_redirect_pc;
                    instr_nxt = NOP_INSTR;
                    vld_nxt   = 1'b0;
                    int_nxt   = 1'b0;
                end else if (pending && !bus.i_stall) begin
                    // Marker carries the PC of the first unexecuted
                    // instruction so decode can push it as the return address.
                    instr_nxt    = NOP_INSTR;
                    pc_plus1_nxt = pc_p0;
                    vld_nxt      = 1'b0;
                    int_nxt      = 1'b1;
                    // A fresh edge in the same cycle keeps the request alive
                    pending_nxt  = int_edge;
                    state_nxt    = ST_INT_VEC;
                end else if (bus.i_stall) begin
                    // Hold PC and IF/ID
                end else begin
                    instr_nxt    = bus.i_imem_data;
                    pc_plus1_nxt = pc_inc(pc_p0);
                    vld_nxt      = 1'b1;
                    int_nxt      = 1'b0;
                    pc_nxt       = pc_inc(pc_p0);
                end
            end

            ST_INT_VEC: begin
                state_nxt = ST_RUN;
                if (bus.i_redirect) begin
                    // The redirect abandons the vector load, so the
                    // interrupt is re-armed and taken again afterwards.
                    pc_nxt      = bus.i_redirect_pc;
                    instr_nxt   = NOP_INSTR;
                    vld_nxt     = 1'b0;
                    int_nxt     = 1'b0;
                    pending_nxt = 1'b1;
                end else begin
                    pc_nxt = bus.i_imem_data;
                    // Marker stays put until decode accepts it
                    if (!bus.i_stall) begin
                        instr_nxt = NOP_INSTR;
                        vld_nxt   = 1'b0;
                        int_nxt   = 1'b0;
                    end
                end
            end

            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    // Instruction memory address selected by state
    always_comb begin
        case (state)
            ST_BOOT:    bus.o_imem_addr = RESET_VEC_ADDR;
            ST_INT_VEC: bus.o_imem_addr = INT_VEC_ADDR;
            default:    bus.o_imem_addr = pc_p0;
        endcase
    end

    // PC, interrupt tracking and IF/ID register update
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc_p0       <= 16'h0000;
            int_q       <= 1'b0;
            pending     <= 1'b0;
            instr_p1    <= NOP_INSTR;
            pc_plus1_p1 <= 16'h0000;
            vld_p1      <= 1'b0;
            int_p1      <= 1'b0;
        end else begin
            pc_p0       <= pc_nxt;
            int_q       <= bus.i_interrupt;
            pending     <= pending_nxt;
            instr_p1    <= instr_nxt;
            pc_plus1_p1 <= pc_plus1_nxt;
            vld_p1      <= vld_nxt;
            int_p1      <= int_nxt;
        end
    end

    assign bus.o_instr     = instr_p1;
    assign bus.o_pc_plus1  = pc_plus1_p1;
    assign bus.o_valid     = vld_p1;
    assign bus.o_interrupt = int_p1;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, stall, redirect, interrupt marker,
// redirect during vector load, PC wrap and reset during vector load.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    int          checks;
    int          failures;
    logic [15:0] mem [0:65535];

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_VEC_ADDR (16'h0000),
        .INT_VEC_ADDR   (16'h0001),
        .NOP_INSTR      (16'h0000)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous instruction memory
    always_comb bus.i_imem_data = mem[bus.o_imem_addr];

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle; valid and marker must never coincide
    task automatic step();
        @(posedge clk);
        #1;
        check_val("excl", 16'(bus.o_valid & bus.o_interrupt), 16'h0000);
    endtask

    task automatic expect_ifid(input string tag, input logic [15:0] instr, input logic [15:0] p1,
                               input logic vld, input logic intr);
        check_val({tag, "_instr"}, bus.o_instr, instr);
        check_val({tag, "_pc1"}, bus.o_pc_plus1, p1);
        check_val({tag, "_vld"}, 16'(bus.o_valid), 16'(vld));
        check_val({tag, "_int"}, 16'(bus.o_interrupt), 16'(intr));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'hA5A5;
        mem[16'h0000] = 16'h0020;
        mem[16'h0001] = 16'h0200;
        mem[16'h0020] = 16'hA001;
        mem[16'h0021] = 16'hB002;
        mem[16'h0022] = 16'hC003;
        mem[16'h0023] = 16'hD004;
        mem[16'h0024] = 16'hE005;
        mem[16'h0100] = 16'h1234;
        mem[16'h0200] = 16'h2222;
        mem[16'hFFFF] = 16'h7777;

        rst               = 1'b1;
        bus.i_stall       = 1'b0;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = 16'h0000;
        bus.i_interrupt   = 1'b0;
        step();
        step();
        expect_ifid("rst", 16'h0000, 16'h0000, 1'b0, 1'b0);
        check_val("rst_addr", bus.o_imem_addr, 16'h0000);

        // Boot
        rst = 1'b0;
        step();
        check_val("boot_vld", 16'(bus.o_valid), 16'h0000);
        check_val("boot_addr", bus.o_imem_addr, 16'h0020);
        step();
        expect_ifid("bootA", 16'hA001, 16'h0021, 1'b1, 1'b0);
        step();
        expect_ifid("bootB", 16'hB002, 16'h0022, 1'b1, 1'b0);
        step();
        expect_ifid("bootC", 16'hC003, 16'h0023, 1'b1, 1'b0);

        // Stall three cycles
        bus.i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            expect_ifid("stall", 16'hC003, 16'h0023, 1'b1, 1'b0);
            check_val("stall_addr", bus.o_imem_addr, 16'h0023);
        end
        bus.i_stall = 1'b0;
        step();
        expect_ifid("postD", 16'hD004, 16'h0024, 1'b1, 1'b0);
        step();
        expect_ifid("postE", 16'hE005, 16'h0025, 1'b1, 1'b0);

        // Redirect overrides stall
        bus.i_stall       = 1'b1;
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 16'h0100;
        step();
        expect_ifid("redir", 16'h0000, 16'h0025, 1'b0, 1'b0);
        check_val("redir_addr", bus.o_imem_addr, 16'h0100);
        bus.i_stall    = 1'b0;
        bus.i_redirect = 1'b0;
        step();
        expect_ifid("redir_tgt", 16'h1234, 16'h0101, 1'b1, 1'b0);

        // Interrupt at pc=30h (edge raised together with redirect to 30h)
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 16'h0030;
        bus.i_interrupt   = 1'b1;
        step();
        check_val("irq_redir_addr", bus.o_imem_addr, 16'h0030);
        bus.i_redirect = 1'b0;
        step();
        expect_ifid("irq_mark", 16'h0000, 16'h0030, 1'b0, 1'b1);
        check_val("irq_vec_addr", bus.o_imem_addr, 16'h0001);
        step();
        check_val("irq_bub_vld", 16'(bus.o_valid), 16'h0000);
        check_val("irq_bub_int", 16'(bus.o_interrupt), 16'h0000);
        check_val("irq_hdl_addr", bus.o_imem_addr, 16'h0200);
        step();
        expect_ifid("irq_hdl", 16'h2222, 16'h0201, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_val("irq_level_int", 16'(bus.o_interrupt), 16'h0000);
            check_val("irq_level_pc1", bus.o_pc_plus1, 16'(16'h0202 + k));
        end

        // Redirect during INT_VEC re-takes the interrupt
        bus.i_interrupt   = 1'b0;
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 16'h0040;
        step();
        check_val("c_redir_addr", bus.o_imem_addr, 16'h0040);
        bus.i_redirect  = 1'b0;
        bus.i_interrupt = 1'b1;
        step();
        expect_ifid("c_fetch", 16'hA5E5, 16'h0041, 1'b1, 1'b0);
        step();
        expect_ifid("c_mark1", 16'h0000, 16'h0041, 1'b0, 1'b1);
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 16'h0050;
        step();
        check_val("c_iv_addr", bus.o_imem_addr, 16'h0050);
        check_val("c_iv_vld", 16'(bus.o_valid), 16'h0000);
        check_val("c_iv_int", 16'(bus.o_interrupt), 16'h0000);
        bus.i_redirect = 1'b0;
        step();
        expect_ifid("c_mark2", 16'h0000, 16'h0050, 1'b0, 1'b1);
        step();
        check_val("c_hdl_addr", bus.o_imem_addr, 16'h0200);
        step();
        expect_ifid("c_hdl", 16'h2222, 16'h0201, 1'b1, 1'b0);
        bus.i_interrupt = 1'b0;

        // PC wrap at FFFFh
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 16'hFFFF;
        step();
        check_val("wrap_addr0", bus.o_imem_addr, 16'hFFFF);
        bus.i_redirect = 1'b0;
        step();
        expect_ifid("wrap", 16'h7777, 16'h0000, 1'b1, 1'b0);
        check_val("wrap_addr1", bus.o_imem_addr, 16'h0000);
        step();
        expect_ifid("wrap_next", 16'h0020, 16'h0001, 1'b1, 1'b0);

        // Reset during INT_VEC with a re-armed request
        bus.i_interrupt = 1'b1;
        step();
        expect_ifid("r_fetch", 16'h0200, 16'h0002, 1'b1, 1'b0);
        step();
        expect_ifid("r_mark", 16'h0000, 16'h0002, 1'b0, 1'b1);
        rst               = 1'b1;
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 16'h0060;
        bus.i_interrupt   = 1'b0;
        step();
        expect_ifid("r_rst", 16'h0000, 16'h0000, 1'b0, 1'b0);
        check_val("r_rst_addr", bus.o_imem_addr, 16'h0000);
        rst            = 1'b0;
        bus.i_redirect = 1'b0;
        step();
        check_val("r_boot_vld", 16'(bus.o_valid), 16'h0000);
        check_val("r_boot_int", 16'(bus.o_interrupt), 16'h0000);
        step();
        expect_ifid("r_A", 16'hA001, 16'h0021, 1'b1, 1'b0);
        step();
        expect_ifid("r_B", 16'hB002, 16'h0022, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
